// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, widths and PC helpers for the fetch sequencer
package fetch_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_HALT, ST_FAULT} state_t;
    localparam int INSTR_W = 32;
    localparam int BYTE_W = 8;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    function automatic logic pc_bad(input logic [31:0] a, input logic [31:0] mem_bytes);
        return (a[1:0] != 2'b00) || (a > mem_bytes - PC_STEP);
    endfunction
endpackage

// File: rtl/imem_byte_writer.sv
// imem_byte_writer: serialises one accepted program word into four big-endian byte writes
module imem_byte_writer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               busy,
    output logic               word_done,
    output logic               word_last,
    output logic [31:0]        wptr,
    output logic               mem_we,
    output logic [31:0]        mem_wadd,
    output logic [BYTE_W-1:0]  mem_wbyte
);
    logic [2:0]         cnt_q, cnt_d;
    logic [31:0]        wptr_q, wptr_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic               last_q, last_d;
    logic [1:0]         k;

    assign busy      = cnt_q != 3'd0;
    assign word_done = cnt_q == 3'd4;
    assign word_last = last_q;
    assign wptr      = wptr_q;
    assign k         = cnt_q[1:0] - 2'd1;
    assign mem_we    = busy;
    assign mem_wadd  = busy ? wptr_q + {30'd0, k} : 32'd0;
    assign mem_wbyte = busy ? word_q[{~k, 3'b000} +: BYTE_W] : '0;

    // capture a word on start, then walk the byte counter and bump wptr after the 4th byte
    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        word_d = word_q;
        last_d = last_q;
        if (start) begin
            cnt_d  = 3'd1;
            word_d = load_data;
            last_d = load_last;
        end else if (busy) begin
            cnt_d  = word_done ? 3'd0 : cnt_q + 3'd1;
            wptr_d = word_done ? wptr_q + PC_STEP : wptr_q;
        end
    end

    // serialiser state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 3'd0;
            wptr_q <= 32'd0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: boots instruction memory from a word loader, then owns the PC and fetch
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 MEM_BYTES = 256,
    parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boot_en,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               mem_we,
    output logic [31:0]        mem_wadd,
    output logic [BYTE_W-1:0]  mem_wbyte,
    output logic [31:0]        mem_radd,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               halted,
    output logic               fault
);
    localparam logic [31:0] MEM_TOP = 32'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_inc, wptr;
    logic        wr_busy, wr_done, wr_last, accept, overflow, halt_hit;

    assign load_ready  = (state_q == ST_LOAD) && !wr_busy;
    assign accept      = load_valid && load_ready;
    assign overflow    = accept && (wptr == MEM_TOP);
    assign pc          = pc_q;
    assign mem_radd    = pc_q;
    assign instr_out   = mem_rdata;
    assign instr_valid = state_q == ST_RUN;
    assign halted      = state_q == ST_HALT;
    assign fault       = state_q == ST_FAULT;
    assign pc_inc      = pc_q + PC_STEP;
    assign halt_hit    = mem_rdata == HALT_WORD;

    imem_byte_writer u_writer (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && !overflow),
        .load_data (load_data),
        .load_last (load_last),
        .busy      (wr_busy),
        .word_done (wr_done),
        .word_last (wr_last),
        .wptr      (wptr),
        .mem_we    (mem_we),
        .mem_wadd  (mem_wadd),
        .mem_wbyte (mem_wbyte)
    );

    // next state and next PC; redirect beats stall beats increment, bad next-PC beats halt
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = boot_en ? ST_LOAD : ST_RUN;
                pc_d    = RESET_PC;
            end
            ST_LOAD: begin
                if (overflow) begin
                    state_d = ST_FAULT;
                end else if (wr_done && wr_last) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = pc_bad(redirect_target, MEM_TOP) ? ST_FAULT : ST_RUN;
                end else if (stall) begin
                    state_d = halt_hit ? ST_HALT : ST_RUN;
                end else if (pc_bad(pc_inc, MEM_TOP)) begin
                    pc_d    = pc_inc;
                    state_d = ST_FAULT;
                end else if (halt_hit) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: ;
        endcase
    end

    // FSM and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3, P_FAULT = 4;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  b;
        bit          fin;
    } wr_t;

    logic        clk = 0, rst = 1, boot_en = 0, load_valid = 0, load_last = 0;
    logic        stall = 0, redirect_valid = 0;
    logic [31:0] load_data = 0, redirect_target = 0, mem_rdata;
    logic        load_ready, mem_we, instr_valid, halted, fault;
    logic [31:0] mem_wadd, mem_radd, pc, instr_out;
    logic [7:0]  mem_wbyte;
    logic [7:0]  mem [256];

    int checks = 0, failures = 0, cyc = 0, we_cnt = 0;
    int m_phase = P_IDLE;
    logic [31:0] m_pc = 0, m_wptr = 0;
    bit m_acc = 0;
    wr_t wq[$];

    logic [31:0] words1 [3];
    logic [31:0] words5 [5];
    logic [31:0] wr [8];
    int exp_pc [6];
    int acc[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .boot_en(boot_en), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .mem_we(mem_we), .mem_wadd(mem_wadd), .mem_wbyte(mem_wbyte),
        .mem_radd(mem_radd), .mem_rdata(mem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc), .instr_out(instr_out), .instr_valid(instr_valid),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // byte-addressed instruction memory seen by the DUT
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_wadd < 32'd256) mem[mem_wadd[7:0]] <= mem_wbyte;
            we_cnt <= we_cnt + 1;
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_radd <= 32'd252)
            mem_rdata = {mem[mem_radd[7:0]], mem[mem_radd[7:0] + 8'd1],
                         mem[mem_radd[7:0] + 8'd2], mem[mem_radd[7:0] + 8'd3]};
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a > 32'd252) return 32'h0;
        return {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    task automatic fill(input bit allow_halt);
        logic [31:0] w;
        for (int i = 0; i < 256; i += 4) begin
            w = $urandom;
            if (!allow_halt) w[31] = 1'b0;
            else if ($urandom % 8 == 0) w = 32'hFFFF_FFFF;
            mem[i] <= w[31:24]; mem[i+1] <= w[23:16]; mem[i+2] <= w[15:8]; mem[i+3] <= w[7:0];
        end
    endtask

    // abstract model: a queue of pending byte writes while loading, a PC while running
    task automatic model_update();
        bit fin, moving;
        logic [31:0] nxt, ins;
        m_acc = 0;
        case (m_phase)
            P_IDLE: begin
                m_phase = boot_en ? P_LOAD : P_RUN;
                m_pc = 0;
                m_wptr = 0;
            end
            P_LOAD: begin
                if (wq.size() != 0) begin
                    fin = wq[0].fin;
                    void'(wq.pop_front());
                    if (fin) begin m_phase = P_RUN; m_pc = 0; end
                end else if (load_valid) begin
                    m_acc = 1;
                    if (m_wptr == 32'd256) m_phase = P_FAULT;
                    else begin
                        for (int k = 0; k < 4; k++)
                            wq.push_back('{m_wptr + 32'(k), 8'(load_data >> (24 - 8 * k)), load_last && k == 3});
                        m_wptr += 4;
                    end
                end
            end
            P_RUN: begin
                ins = rd(m_pc);
                nxt = redirect_valid ? redirect_target : stall ? m_pc : m_pc + 4;
                moving = redirect_valid || !stall;
                if (moving && (nxt % 4 != 0 || nxt > 32'd252)) begin
                    m_pc = nxt;
                    m_phase = P_FAULT;
                end else if (!redirect_valid && ins == 32'hFFFF_FFFF) m_phase = P_HALT;
                else m_pc = nxt;
            end
            default: ;
        endcase
    endtask

    // called at a negedge with inputs already driven; compares, advances model, waits one cycle
    task automatic step();
        #1;
        chk("load_ready", 32'(load_ready), 32'(m_phase == P_LOAD && wq.size() == 0));
        chk("mem_we", 32'(mem_we), 32'(wq.size() != 0));
        if (wq.size() != 0) begin
            chk("mem_wadd", mem_wadd, wq[0].a);
            chk("mem_wbyte", 32'(mem_wbyte), 32'(wq[0].b));
        end
        chk("instr_valid", 32'(instr_valid), 32'(m_phase == P_RUN));
        chk("pc", pc, m_pc);
        chk("mem_radd", mem_radd, m_pc);
        if (m_phase == P_RUN) chk("instr_out", instr_out, rd(m_pc));
        chk("halted", 32'(halted), 32'(m_phase == P_HALT));
        chk("fault", 32'(fault), 32'(m_phase == P_FAULT));
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    // assert rst at the current negedge; outputs must clear immediately
    task automatic reset_dut();
        rst = 1; boot_en = 0; load_valid = 0; load_last = 0; stall = 0; redirect_valid = 0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_radd", mem_radd, 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_wadd", mem_wadd, 32'h0);
        chk("rst_wbyte", 32'(mem_wbyte), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        m_phase = P_IDLE; m_pc = 0; m_wptr = 0; wq.delete();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wi, we0, n, r;
        words1 = '{32'h0011_10AA, 32'h0011_15AA, 32'hFFFF_FFFF};
        exp_pc = '{0, 4, 4, 4, 4, 8};
        @(negedge clk);

        // boot three words, run to halt
        fill(0);
        reset_dut();
        boot_en = 1; step(); boot_en = 0;
        wi = 0; we0 = we_cnt;
        for (int i = 0; i < 40 && m_phase == P_LOAD; i++) begin
            load_valid = wi < 3;
            load_data = words1[wi < 3 ? wi : 2];
            load_last = wi == 2;
            step();
            if (m_acc) wi++;
        end
        load_valid = 0; load_last = 0;
        chk("t1_bytes0", {mem[0], mem[1], mem[2], mem[3]}, 32'h0011_10AA);
        chk("t1_bytes1", {mem[4], mem[5], mem[6], mem[7]}, 32'h0011_15AA);
        chk("t1_bytes2", {mem[8], mem[9], mem[10], mem[11]}, 32'hFFFF_FFFF);
        chk("t1_we_count", 32'(we_cnt - we0), 32'd12);
        chk("t1_pc0", pc, 32'h0);
        chk("t1_instr0", instr_out, 32'h0011_10AA);
        step();
        chk("t1_instr1", instr_out, 32'h0011_15AA);
        step();
        chk("t1_pc2", pc, 32'h8);
        step();
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_halt_pc", pc, 32'h8);
        chk("t1_halt_valid", 32'(instr_valid), 32'h0);
        redirect_valid = 1; redirect_target = 0; step(); redirect_valid = 0;
        chk("t1_halt_frozen", pc, 32'h8);

        // no boot, stall sequence
        fill(0);
        reset_dut();
        we0 = we_cnt;
        step();
        chk("t6_pc", pc, 32'h0);
        chk("t6_valid", 32'(instr_valid), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("t2_pc_seq", pc, 32'(exp_pc[i]));
            stall = (i >= 1 && i <= 3);
            step();
        end
        stall = 0;
        chk("t6_no_we", 32'(we_cnt - we0), 32'h0);

        // redirect under stall suppresses halt
        mem[4] <= 8'hFF; mem[5] <= 8'hFF; mem[6] <= 8'hFF; mem[7] <= 8'hFF;
        redirect_valid = 1; redirect_target = 32'h4; step();
        stall = 1; redirect_target = 32'h10; step();
        stall = 0; redirect_valid = 0;
        chk("t3_pc", pc, 32'h10);
        chk("t3_no_halt", 32'(halted), 32'h0);
        chk("t3_valid", 32'(instr_valid), 32'h1);

        // misaligned redirect faults
        redirect_valid = 1; redirect_target = 32'h12; step(); redirect_valid = 0;
        chk("t4_fault", 32'(fault), 32'h1);
        chk("t4_pc", pc, 32'h12);
        chk("t4_valid", 32'(instr_valid), 32'h0);

        // increment past end of memory faults
        fill(0);
        reset_dut();
        step();
        redirect_valid = 1; redirect_target = 32'hFC; step(); redirect_valid = 0;
        chk("t4b_pc", pc, 32'hFC);
        step();
        chk("t4b_fault", 32'(fault), 32'h1);
        chk("t4b_pc_next", pc, 32'h100);

        // load_valid held high: one accept every five cycles
        fill(0);
        reset_dut();
        for (int i = 0; i < 5; i++) words5[i] = $urandom & 32'h7FFF_FFFF;
        boot_en = 1; step(); boot_en = 0;
        wi = 0; acc.delete();
        load_valid = 1;
        for (int i = 0; i < 60 && m_phase == P_LOAD; i++) begin
            load_data = words5[wi < 5 ? wi : 4];
            load_last = wi == 4;
            step();
            if (m_acc) begin acc.push_back(cyc); wi++; end
        end
        load_valid = 0; load_last = 0;
        chk("t5_words", 32'(wi), 32'd5);
        for (int i = 1; i < acc.size(); i++) chk("t5_spacing", 32'(acc[i] - acc[i-1]), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("t5_mem", {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]}, words5[i]);

        // reset in the middle of a word write, then reboot from address 0
        reset_dut();
        boot_en = 1; step(); boot_en = 0;
        load_valid = 1; load_data = 32'hA1B2_C3D4; step(); load_valid = 0;
        step(); step();
        chk("t5b_byte2", 32'(mem_wbyte), 32'hC3);
        reset_dut();
        boot_en = 1; step(); boot_en = 0;
        load_valid = 1; load_data = 32'h5566_7788; load_last = 1; step();
        load_valid = 0; load_last = 0;
        for (int i = 0; i < 10 && m_phase == P_LOAD; i++) step();
        chk("t5b_reboot", {mem[0], mem[1], mem[2], mem[3]}, 32'h5566_7788);

        // overflow: 65th word faults without writing
        fill(0);
        reset_dut();
        we0 = we_cnt;
        boot_en = 1; step(); boot_en = 0;
        for (int i = 0; i < 400 && m_phase == P_LOAD; i++) begin
            load_valid = 1; load_data = $urandom; load_last = 0;
            step();
        end
        load_valid = 0;
        chk("ovf_fault", 32'(fault), 32'h1);
        chk("ovf_we_count", 32'(we_cnt - we0), 32'd256);

        // randomized boots and runs
        for (int it = 0; it < 12; it++) begin
            fill(1);
            reset_dut();
            boot_en = $urandom % 2;
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) wr[i] = ($urandom % 6 == 0) ? 32'hFFFF_FFFF : $urandom;
            step();
            boot_en = 0;
            wi = 0;
            for (int i = 0; i < 200 && m_phase == P_LOAD; i++) begin
                load_valid = (wi < n) && ($urandom % 2 == 0);
                load_data = wr[wi < n ? wi : n - 1];
                load_last = wi == n - 1;
                step();
                if (m_acc) wi++;
            end
            load_valid = 0; load_last = 0;
            for (int i = 0; i < 80 && m_phase == P_RUN; i++) begin
                stall = $urandom % 4 == 0;
                redirect_valid = $urandom % 6 == 0;
                r = $urandom % 16;
                redirect_target = r == 0 ? 32'($urandom_range(0, 255)) :
                                  r == 1 ? 32'h100 + 32'($urandom_range(0, 64)) :
                                  {22'd0, 8'($urandom_range(0, 63)), 2'b00};
                step();
            end
            stall = 0; redirect_valid = 0;
            step(); step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
